// File: rtl/freq_meter_ctrl.sv
// Gate/latch controller for a 6-digit BCD frequency counter: clears, gates, settles and latches the count.
// Define FREQ_METER_LEADZERO_BLANK_EN to build the leading-zero blank mask; otherwise digit_blank is tied low.
module freq_meter_ctrl #(
  parameter int GATE_CYCLES   = 1000,
  parameter int CLEAR_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [23:0] q_in,
  output logic        cnt_ena,
  output logic        cnt_clr,
  output logic [23:0] q_out,
  output logic        q_valid,
  output logic        busy,
  output logic [5:0]  digit_blank
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SETTLE,
    LATCH
  } state_t;

  localparam logic [CNT_W-1:0] CLEAR_LOAD  = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             run_s;
  logic             cnt_done;
  logic             latch_entry;

  assign cnt_done    = (cnt == '0);
  assign latch_entry = (state == SETTLE) && cnt_done;

  // run is registered first, so a request seen at one edge opens CLEAR at the next
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      run_s   <= 1'b0;
      cnt_ena <= 1'b0;
      cnt_clr <= 1'b0;
      q_out   <= '0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      run_s   <= run;
      q_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (run_s) begin
            state   <= CLEAR;
            cnt     <= CLEAR_LOAD;
            cnt_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_done) begin
            state   <= GATE;
            cnt     <= GATE_LOAD;
            cnt_clr <= 1'b0;
            cnt_ena <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        GATE: begin
          if (cnt_done) begin
            state   <= SETTLE;
            cnt     <= SETTLE_LOAD;
            cnt_ena <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        SETTLE: begin
          if (cnt_done) begin
            state   <= LATCH;
            cnt     <= '0;
            q_out   <= q_in;
            q_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        LATCH: begin
          if (run_s) begin
            state   <= CLEAR;
            cnt     <= CLEAR_LOAD;
            cnt_clr <= 1'b1;
          end else begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          cnt_ena <= 1'b0;
          cnt_clr <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FREQ_METER_LEADZERO_BLANK_EN
  logic [5:0] digit_zero;
  logic [5:0] blank_next;

  for (genvar i = 0; i < 6; i++) begin : g_zero
    assign digit_zero[i] = (q_in[4*i +: 4] == 4'd0);
  end

  // a digit blanks only when it and every more significant digit are zero
  assign blank_next[5] = digit_zero[5];
  assign blank_next[4] = blank_next[5] & digit_zero[4];
  assign blank_next[3] = blank_next[4] & digit_zero[3];
  assign blank_next[2] = blank_next[3] & digit_zero[2];
  assign blank_next[1] = blank_next[2] & digit_zero[1];
  assign blank_next[0] = 1'b0;

  always_ff @(posedge clk) begin
    if (clr) begin
      digit_blank <= '0;
    end else if (latch_entry) begin
      digit_blank <= blank_next;
    end
  end
`else
  assign digit_blank = 6'b000000;
`endif

  assert property (@(posedge clk) !(cnt_clr && cnt_ena));

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Directed bench for freq_meter_ctrl with GATE=10, CLEAR=2, SETTLE=2 (15-cycle measurement period).
module tb_freq_meter_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic [23:0] q_in;
  logic        cnt_ena;
  logic        cnt_clr;
  logic [23:0] q_out;
  logic        q_valid;
  logic        busy;
  logic [5:0]  digit_blank;

  int          total = 0;
  int          bad = 0;
  logic [23:0] model_q = '0;
  logic [5:0]  model_blank = '0;

  freq_meter_ctrl #(
    .GATE_CYCLES(10),
    .CLEAR_CYCLES(2),
    .SETTLE_CYCLES(2),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .clr(clr),
    .run(run),
    .q_in(q_in),
    .cnt_ena(cnt_ena),
    .cnt_clr(cnt_clr),
    .q_out(q_out),
    .q_valid(q_valid),
    .busy(busy),
    .digit_blank(digit_blank)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  // advance one edge and move 1 time unit past it before inputs change or outputs are read
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] exp_blank(input logic [23:0] v);
    logic [5:0] r;
    r = '0;
`ifdef FREQ_METER_LEADZERO_BLANK_EN
    for (int i = 1; i < 6; i++) r[i] = ((v >> (4 * i)) == 24'd0);
`endif
    return r;
  endfunction

  // runs edges first_e..15 of a measurement whose run request was sampled at edge 0
  task automatic measure(input logic [23:0] cap, input int drop_at, input bit toggle, input int first_e);
    for (int e = first_e; e <= 15; e++) begin
      if (e == drop_at) run = 1'b0;
      if (toggle && e >= 3 && e <= 14) q_in = 24'($urandom);
      else q_in = cap;
      applyStimulus();
      if (e == 15) begin
        model_q     = cap;
        model_blank = exp_blank(cap);
      end
      checkOutput($sformatf("cnt_clr@%0d", e), 32'(cnt_clr), 32'(e <= 2));
      checkOutput($sformatf("cnt_ena@%0d", e), 32'(cnt_ena), 32'(e >= 3 && e <= 12));
      checkOutput($sformatf("q_valid@%0d", e), 32'(q_valid), 32'(e == 15));
      checkOutput($sformatf("busy@%0d", e), 32'(busy), 32'd1);
      checkOutput($sformatf("q_out@%0d", e), 32'(q_out), 32'(model_q));
      checkOutput($sformatf("blank@%0d", e), 32'(digit_blank), 32'(model_blank));
    end
  endtask

  task automatic check_idle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_clr"}, 32'(cnt_clr), 32'd0);
    checkOutput({tag, "_ena"}, 32'(cnt_ena), 32'd0);
    checkOutput({tag, "_valid"}, 32'(q_valid), 32'd0);
    checkOutput({tag, "_qout"}, 32'(q_out), 32'(model_q));
  endtask

  initial begin
    clr  = 1'b1;
    run  = 1'b1;
    q_in = 24'h000123;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      check_idle($sformatf("rst%0d", i));
      checkOutput($sformatf("rst%0d_blank", i), 32'(digit_blank), 32'd0);
    end

    // first measurement: run held high, so a second measurement follows immediately
    clr = 1'b0;
    applyStimulus();
    check_idle("edge0");
    measure(24'h000123, -1, 1'b0, 1);
    applyStimulus();
    checkOutput("b2b_clr@16", 32'(cnt_clr), 32'd1);
    checkOutput("b2b_busy@16", 32'(busy), 32'd1);
    checkOutput("b2b_valid@16", 32'(q_valid), 32'd0);

    // second measurement: run dropped during GATE, completes and returns to IDLE
    measure(24'h000000, 6, 1'b0, 2);
    applyStimulus();
    check_idle("drop@16");
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      check_idle($sformatf("drop_idle%0d", i));
    end

    // q_in churning during GATE/SETTLE, only the value at the latch edge lands
    run = 1'b1;
    applyStimulus();
    check_idle("tog_e0");
    measure(24'h999999, 1, 1'b1, 1);
    applyStimulus();
    check_idle("tog@16");

    run = 1'b1;
    applyStimulus();
    check_idle("b120_e0");
    measure(24'h000120, 1, 1'b0, 1);
    applyStimulus();
    check_idle("b120@16");

    // clr pulsed mid-GATE abandons the measurement
    run  = 1'b1;
    q_in = 24'h054321;
    applyStimulus();
    run = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      applyStimulus();
      checkOutput($sformatf("abort_ena@%0d", e), 32'(cnt_ena), 32'(e >= 3));
    end
    clr = 1'b1;
    applyStimulus();
    model_q     = '0;
    model_blank = '0;
    check_idle("abort@8");
    checkOutput("abort_blank@8", 32'(digit_blank), 32'd0);
    clr = 1'b0;
    for (int e = 9; e <= 20; e++) begin
      applyStimulus();
      check_idle($sformatf("post_abort@%0d", e));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_meter_ctrl.md
# freq_meter_ctrl

- Gate/latch controller for the 6-digit BCD frequency counter chain.
- Sits directly upstream of the counter: drives its enable (`cnt_ena`) and clear (`cnt_clr`) from a reference clock `clk`.
- Sits directly downstream of the counter: captures its 24-bit BCD result (`q_in`) into a stable display register after each gate window.
- Runs one measurement per trigger, or back-to-back measurements while `run` stays high.

## Interface
- `GATE_CYCLES`, 1000: `clk` cycles `cnt_ena` is held high per measurement; 1000 gives a 1 s gate at a 1 kHz `clk`; must be ≥1.
- `CLEAR_CYCLES`, 2: `clk` cycles `cnt_clr` is held high before each gate; must be ≥1 and cover at least one input-frequency edge, because the counter samples clear on its input clock.
- `SETTLE_CYCLES`, 2: idle cycles between gate close and latch, letting the ripple-carry chain settle; must be ≥1.
- `CNT_W`, 16: width of the internal cycle counter; must hold max(GATE_CYCLES, CLEAR_CYCLES, SETTLE_CYCLES).
- `clk` in 1: reference clock; the block's single clock.
- `clr` in 1: reset, synchronous to `clk`, active-high.
- `run` in 1: measurement request; sampled only in IDLE.
- `q_in` in 24: BCD count from the counter chain, digit 0 in [3:0].
- `cnt_ena` out 1: count enable to the counter chain.
- `cnt_clr` out 1: clear to the counter chain.
- `q_out` out 24: latched BCD result.
- `q_valid` out 1: one-cycle pulse, high in the cycle `q_out` shows a new result.
- `busy` out 1: high in every state except IDLE.
- `digit_blank` out 6: leading-zero blank mask per digit (see Configuration).

## Operation
- All outputs are registered and all state changes happen on `posedge clk`.
- Reset (`clr`=1 at an edge): state IDLE, internal counter 0, and `cnt_ena`=0, `cnt_clr`=0, `q_out`=0, `q_valid`=0, `busy`=0, `digit_blank`=0.
- Reset has priority over everything, including mid-measurement: any in-flight measurement is abandoned and no `q_valid` is produced.
- States: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE: `cnt_ena`=0, `cnt_clr`=0. `run`=1 → CLEAR; otherwise stay in IDLE.
- CLEAR: `cnt_clr`=1 for exactly CLEAR_CYCLES cycles → GATE.
- GATE: `cnt_ena`=1 for exactly GATE_CYCLES cycles → SETTLE. `cnt_clr` and `cnt_ena` are never high together.
- SETTLE: `cnt_ena`=0 for SETTLE_CYCLES cycles → LATCH.
- LATCH: lasts one cycle.
  - On entry, `q_out` ← `q_in` and `q_valid`=1.
  - Exit: `run`=1 → CLEAR (back-to-back measurement); otherwise → IDLE.
- `run` is ignored in CLEAR, GATE and SETTLE: dropping it mid-measurement does not abort; the measurement completes and the block then returns to IDLE.
- `q_out` changes only on LATCH entry or reset. `q_in` activity at any other time has no effect on `q_out`.
- No BCD validation or saturation: `q_in` is copied verbatim, including counter wrap (999999 → 000000).
- The internal counter counts down from N−1 to 0 in each timed state and reloads on every state change.

## Timing
- If `run` is sampled high at edge k in IDLE:
  - `cnt_clr` is high after edges k+1 … k+CLEAR_CYCLES.
  - `cnt_ena` is high for the following GATE_CYCLES cycles.
  - LATCH is entered at edge k+1+CLEAR_CYCLES+GATE_CYCLES+SETTLE_CYCLES; `q_out` and `q_valid` update at that edge.
- Measurement period (latch to latch while `run` stays high) = CLEAR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+1 cycles.
- `busy` rises at edge k+1 and falls at the edge that leaves LATCH for IDLE.
- `clr` released at edge r: `run` can first be sampled at edge r+1.

## Configuration
- Macro: `FREQ_METER_LEADZERO_BLANK_EN`.
- Defined:
  - Updated at LATCH entry: `digit_blank[i]`=1 for i=1..5 when digit i and all higher digits of the captured value are 0.
  - `digit_blank[0]` is always 0.
  - Reset value is 0.
- Undefined: the `digit_blank` port still exists and is tied to 6'b000000; no blanking logic is compiled.

## Test plan
All scenarios use GATE_CYCLES=10, CLEAR_CYCLES=2, SETTLE_CYCLES=2, so the period is 15 cycles.
- Reset: `clr`=1 for 2 edges with `run`=1 → all outputs 0, `busy`=0; the first CLEAR starts only after `clr` drops.
- `run`=1 sampled at edge 0, `q_in`=24'h000123 → `cnt_clr` high after edges 1–2, `cnt_ena` high after edges 3–12, `q_valid` pulse and `q_out`=24'h000123 at edge 15, `cnt_clr` high again at edge 16.
- `run` dropped at edge 6 (during GATE) → gate completes, a single `q_valid` at edge 15, IDLE at edge 16 with `busy`=0; no further `cnt_clr`.
- `clr` pulsed at edge 8 (during GATE) → at edge 8 `cnt_ena`=0, `q_out`=0, `busy`=0; no `q_valid` afterwards.
- `q_in` toggled every cycle during GATE/SETTLE, then 24'h999999 at edge 15 → `q_out`=24'h999999 only; `q_out` is unchanged in every other cycle.
- Macro defined:
  - captured 24'h000120 → `digit_blank`=6'b111000.
  - captured 24'h000000 → `digit_blank`=6'b111110.
- Macro undefined: `digit_blank` stays 6'b000000 for every captured value.
